// File: rtl/dcache_pkg.sv
// Shared types and widths for the D-cache line filler.
package dcache_pkg;

  localparam int INDEX_W       = 10;
  localparam int WAY_W         = 2;
  localparam int BEAT_W        = 128;
  localparam int QW_W          = 2;
  localparam int LINE_QUARTERS = 4;
  localparam int ADDR_W        = INDEX_W + WAY_W;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic [WAY_W-1:0]   way;
    logic [QW_W-1:0]    qw;
  } fill_req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_e;

  // One-hot bank select for a quarter number.
  function automatic logic [LINE_QUARTERS-1:0] quarter_onehot(input logic [QW_W-1:0] q);
    return 4'b0001 << q;
  endfunction

endpackage

// File: rtl/dcache_line_filler.sv
// D-cache line filler: takes a fill command, then four memory beats
// (critical quarter first, wrapping mod 4), and writes each into its
// quarter-line bank at {index, way}. Pulses fill_done when the line is in.
// Optional: LINE_FILL_CWF_EN adds cwf_valid/cwf_data, forwarding the
// critical beat in the cycle it is written.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid may be held or dropped freely, ready never depends on valid.
module dcache_line_filler
  import dcache_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [INDEX_W-1:0]       req_index,
  input  logic [WAY_W-1:0]         req_way,
  input  logic [QW_W-1:0]          req_qw,
  input  logic                     beat_valid,
  output logic                     beat_ready,
  input  logic [BEAT_W-1:0]        beat_data,
  input  logic                     beat_last,
  output logic [LINE_QUARTERS-1:0] bank_wr_en,
  output logic [ADDR_W-1:0]        bank_wr_addr,
  output logic [BEAT_W-1:0]        bank_wr_data,
  output logic                     fill_done,
  output logic [INDEX_W-1:0]       fill_index,
  output logic [WAY_W-1:0]         fill_way,
  output logic                     proto_err,
`ifdef LINE_FILL_CWF_EN
  output logic                     cwf_valid,
  output logic [BEAT_W-1:0]        cwf_data,
`endif
  output logic                     busy
);

  fill_state_e              state_q;
  fill_req_t                req_q;
  logic [QW_W-1:0]          cnt_q;
  logic                     req_ready_q;
  logic                     beat_ready_q;
  logic                     busy_q;
  logic [LINE_QUARTERS-1:0] wr_en_q;
  logic [ADDR_W-1:0]        wr_addr_q;
  logic [BEAT_W-1:0]        wr_data_q;
  logic                     fill_done_q;
  logic [INDEX_W-1:0]       fill_index_q;
  logic [WAY_W-1:0]         fill_way_q;
  logic                     proto_err_q;
`ifdef LINE_FILL_CWF_EN
  logic                     cwf_valid_q;
  logic [BEAT_W-1:0]        cwf_data_q;
`endif

  logic beat_acc;
  logic last_beat;
  assign beat_acc  = beat_valid && beat_ready_q;
  assign last_beat = (cnt_q == 2'd3);

  // Fill FSM with all outputs registered; strobes default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      beat_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      wr_en_q      <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      fill_done_q  <= 1'b0;
      fill_index_q <= '0;
      fill_way_q   <= '0;
      proto_err_q  <= 1'b0;
`ifdef LINE_FILL_CWF_EN
      cwf_valid_q  <= 1'b0;
      cwf_data_q   <= '0;
`endif
    end else begin
      wr_en_q     <= '0;
      fill_done_q <= 1'b0;
      proto_err_q <= 1'b0;
`ifdef LINE_FILL_CWF_EN
      cwf_valid_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            req_q        <= '{index: req_index, way: req_way, qw: req_qw};
            cnt_q        <= '0;
            state_q      <= FILL;
            req_ready_q  <= 1'b0;
            beat_ready_q <= 1'b1;
            busy_q       <= 1'b1;
          end else begin
            // Ready comes up one cycle after reset release.
            req_ready_q <= 1'b1;
          end
        end
        FILL: begin
          if (beat_acc) begin
            wr_en_q     <= quarter_onehot(req_q.qw + cnt_q);
            wr_addr_q   <= {req_q.index, req_q.way};
            wr_data_q   <= beat_data;
            // beat_last must be set on beat 3 and only there.
            proto_err_q <= (beat_last != last_beat);
            cnt_q       <= cnt_q + 2'd1;
`ifdef LINE_FILL_CWF_EN
            if (cnt_q == 2'd0) begin
              cwf_valid_q <= 1'b1;
              cwf_data_q  <= beat_data;
            end
`endif
            if (last_beat) begin
              state_q      <= DONE;
              beat_ready_q <= 1'b0;
              fill_done_q  <= 1'b1;
              fill_index_q <= req_q.index;
              fill_way_q   <= req_q.way;
            end
          end
        end
        DONE: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b0;
          beat_ready_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign beat_ready   = beat_ready_q;
  assign busy         = busy_q;
  assign bank_wr_en   = wr_en_q;
  assign bank_wr_addr = wr_addr_q;
  assign bank_wr_data = wr_data_q;
  assign fill_done    = fill_done_q;
  assign fill_index   = fill_index_q;
  assign fill_way     = fill_way_q;
  assign proto_err    = proto_err_q;
`ifdef LINE_FILL_CWF_EN
  assign cwf_valid    = cwf_valid_q;
  assign cwf_data     = cwf_data_q;
`endif

endmodule

// File: tb/tb_dcache_line_filler.sv
// Directed bench for dcache_line_filler. Define LINE_FILL_CWF_EN to also
// cover the critical-word-forward ports.
module tb_dcache_line_filler;
  import dcache_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                     req_valid = 1'b0;
  logic                     req_ready;
  logic [INDEX_W-1:0]       req_index = '0;
  logic [WAY_W-1:0]         req_way = '0;
  logic [QW_W-1:0]          req_qw = '0;
  logic                     beat_valid = 1'b0;
  logic                     beat_ready;
  logic [BEAT_W-1:0]        beat_data = '0;
  logic                     beat_last = 1'b0;
  logic [LINE_QUARTERS-1:0] bank_wr_en;
  logic [ADDR_W-1:0]        bank_wr_addr;
  logic [BEAT_W-1:0]        bank_wr_data;
  logic                     fill_done;
  logic [INDEX_W-1:0]       fill_index;
  logic [WAY_W-1:0]         fill_way;
  logic                     proto_err;
  logic                     busy;
`ifdef LINE_FILL_CWF_EN
  logic                     cwf_valid;
  logic [BEAT_W-1:0]        cwf_data;
`endif

  dcache_line_filler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_index    (req_index),
    .req_way      (req_way),
    .req_qw       (req_qw),
    .beat_valid   (beat_valid),
    .beat_ready   (beat_ready),
    .beat_data    (beat_data),
    .beat_last    (beat_last),
    .bank_wr_en   (bank_wr_en),
    .bank_wr_addr (bank_wr_addr),
    .bank_wr_data (bank_wr_data),
    .fill_done    (fill_done),
    .fill_index   (fill_index),
    .fill_way     (fill_way),
    .proto_err    (proto_err),
`ifdef LINE_FILL_CWF_EN
    .cwf_valid    (cwf_valid),
    .cwf_data     (cwf_data),
`endif
    .busy         (busy)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [BEAT_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // exp_en holds the hand-computed enable for beat k in nibble k.
  task automatic run_fill(input logic [INDEX_W-1:0] idx, input logic [WAY_W-1:0] way,
                          input logic [QW_W-1:0] qw, input logic [15:0] exp_en,
                          input logic [ADDR_W-1:0] exp_addr, input logic [BEAT_W-1:0] base,
                          input int gap, input logic [3:0] last_mask, input logic [3:0] err_mask);
    req_valid = 1'b1;
    req_index = idx;
    req_way   = way;
    req_qw    = qw;
    tick();
    req_valid = 1'b0;
    check("busy_after_req", busy, 1);
    check("req_ready_in_fill", req_ready, 0);
    check("beat_ready_in_fill", beat_ready, 1);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        beat_valid = 1'b0;
        tick();
        check("gap_wr_en", bank_wr_en, 0);
        check("gap_req_ready", req_ready, 0);
      end
      beat_valid = 1'b1;
      beat_data  = base + BEAT_W'(k);
      beat_last  = last_mask[k];
      exp_q.push_back(base + BEAT_W'(k));
      tick();
      beat_valid = 1'b0;
      beat_last  = 1'b0;
      check("wr_en", bank_wr_en, exp_en[4*k +: 4]);
      check("wr_addr", bank_wr_addr, exp_addr);
      check("wr_data", bank_wr_data, exp_q.pop_front());
      check("proto_err", proto_err, err_mask[k]);
      check("fill_done", fill_done, (k == 3) ? 1 : 0);
`ifdef LINE_FILL_CWF_EN
      check("cwf_valid", cwf_valid, (k == 0) ? 1 : 0);
      if (k == 0) check("cwf_data", cwf_data, base);
`endif
      if (k == 3) begin
        check("fill_index", fill_index, idx);
        check("fill_way", fill_way, way);
        check("beat_ready_done", beat_ready, 0);
        check("req_ready_done", req_ready, 0);
      end
    end
    tick();
    check("idle_wr_en", bank_wr_en, 0);
    check("idle_fill_done", fill_done, 0);
    check("idle_req_ready", req_ready, 1);
    check("idle_busy", busy, 0);
    check("hold_fill_index", fill_index, idx);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2;
    check("rst_req_ready", req_ready, 0);
    check("rst_beat_ready", beat_ready, 0);
    check("rst_wr_en", bank_wr_en, 0);
    check("rst_wr_addr", bank_wr_addr, 0);
    check("rst_wr_data", bank_wr_data, 0);
    check("rst_fill_done", fill_done, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_busy", busy, 0);
    check("rst_fill_index", fill_index, 0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_req_ready", req_ready, 1);

    // 1: qw=0, back-to-back -> 0001,0010,0100,1000 at 0x556
    run_fill(10'h155, 2'd2, 2'd0, 16'h8421, 12'h556, 128'hA0, 0, 4'b1000, 4'b0000);

    // 2: qw=3 wraps -> 1000,0001,0010,0100 at 0xFFD
    run_fill(10'h3FF, 2'd1, 2'd3, 16'h4218, 12'hFFD, 128'hB0, 0, 4'b1000, 4'b0000);

    // 3: beats offered in IDLE are dropped, then a fill with 2-cycle gaps
    beat_valid = 1'b1;
    beat_data  = 128'hBAD;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("idle_beat_ready", beat_ready, 0);
      check("idle_beat_no_write", bank_wr_en, 0);
    end
    beat_valid = 1'b0;
    run_fill(10'h0A5, 2'd3, 2'd2, 16'h2184, 12'h297, 128'hC0, 2, 4'b1000, 4'b0000);

    // 4: beat_last on beat 1 -> errors on beat 1 and on beat 3 (no last)
    run_fill(10'h001, 2'd0, 2'd1, 16'h1842, 12'h004, 128'hD0, 0, 4'b0010, 4'b1010);

    // 5: reset after two beats
    req_valid = 1'b1;
    req_index = 10'h2AA;
    req_way   = 2'd1;
    req_qw    = 2'd0;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      beat_valid = 1'b1;
      beat_data  = 128'hE0 + BEAT_W'(k);
      tick();
    end
    beat_valid = 1'b0;
    check("pre_rst_wr_en", bank_wr_en, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr_en", bank_wr_en, 0);
    check("mid_rst_wr_addr", bank_wr_addr, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_beat_ready", beat_ready, 0);
    check("mid_rst_fill_done", fill_done, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("in_rst_fill_done", fill_done, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rerst_req_ready", req_ready, 1);
    check("rerst_fill_done", fill_done, 0);
    run_fill(10'h155, 2'd2, 2'd0, 16'h8421, 12'h556, 128'hF0, 0, 4'b1000, 4'b0000);

    // 6: qw=2 critical beat; forward ports checked when present
    run_fill(10'h010, 2'd0, 2'd2, 16'h2184, 12'h040,
             128'hDEAD_BEEF_0000_1111_2222_3333_4444_5550, 0, 4'b1000, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
